// File: rtl/adder_sequencer.sv
// adder_sequencer: queued control sequencer for a small accumulator datapath.
// Instructions are buffered in a DEPTH-entry FIFO, then expanded into one or two
// cycles of control word (register loads, ALU drive, display strobe). The last
// cycle of every instruction dispatches the next queued one directly, so a full
// queue streams without idle bubbles between instructions.
module adder_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [2:0] instr_op,
    output logic       instr_ready,
    input  logic       resume,
    input  logic       cf_in,
    input  logic       zf_in,
    output logic       bus_regA_sel,
    output logic       nLa,
    output logic       nLb,
    output logic       Ea,
    output logic       Eu,
    output logic       sub,
    output logic       out_strobe,
    output logic       halted,
    output logic       cf_q,
    output logic       zf_q,
    output logic [7:0] retired
);

    // Queue pointer and occupancy widths; occupancy needs one extra bit to hold DEPTH.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Opcodes.
    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpLda  = 3'b001;
    localparam logic [2:0] OpLdb  = 3'b010;
    localparam logic [2:0] OpAdd  = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpOut  = 3'b101;
    localparam logic [2:0] OpSkz  = 3'b110;
    localparam logic [2:0] OpHalt = 3'b111;

    // Sequencer states.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExec1  = 2'd1;
    localparam logic [1:0] StExec2  = 2'd2;
    localparam logic [1:0] StHalted = 2'd3;

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;

    // Readiness looks only at registered occupancy; a same-cycle pop does not
    // open a slot early.
    assign instr_ready = (count_q < CW'(DEPTH));
    assign push        = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] ir_q;
    logic [2:0] ir_d;
    logic       skip_q;
    logic       skip_d;
    logic       retire;
    logic       flag_load;
    logic       finish;
    logic       is_alu_op;

    assign is_alu_op = (ir_q == OpAdd) || (ir_q == OpSub);

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_op;
        end
    end

    // Queue pointers advance on push/pop and wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state logic: decode the current instruction phase and, on its final
    // cycle, either dispatch the queue head or fall back to IDLE.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        skip_d    = skip_q;
        pop       = 1'b0;
        retire    = 1'b0;
        flag_load = 1'b0;
        finish    = 1'b0;

        unique case (state_q)
            StIdle: begin
                finish = 1'b1;
            end
            StExec1: begin
                if (skip_q) begin
                    // Instruction shadowed by a taken SKZ: burn one idle cycle, no retire.
                    skip_d = 1'b0;
                    finish = 1'b1;
                end else begin
                    case (ir_q)
                        OpLda, OpLdb, OpAdd, OpSub: begin
                            state_d = StExec2;
                        end
                        OpHalt: begin
                            state_d = StHalted;
                            retire  = 1'b1;
                        end
                        OpSkz: begin
                            retire = 1'b1;
                            finish = 1'b1;
                            if (zf_q) begin
                                skip_d = 1'b1;
                            end
                        end
                        default: begin
                            retire = 1'b1;
                            finish = 1'b1;
                        end
                    endcase
                end
            end
            StExec2: begin
                retire    = 1'b1;
                finish    = 1'b1;
                flag_load = is_alu_op;
            end
            StHalted: begin
                if (resume) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            if (count_q != '0) begin
                pop     = 1'b1;
                ir_d    = mem_q[rd_ptr_q];
                state_d = StExec1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Sequencer registers: state, instruction register and skip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= OpNop;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            skip_q  <= skip_d;
        end
    end

    // ALU flags are captured at the end of the ADD/SUB settle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else if (flag_load) begin
            cf_q <= cf_in;
            zf_q <= zf_in;
        end
    end

    // Retired-instruction counter, wraps modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Control word decode (Moore: depends only on registered state)
    // ------------------------------------------------------------------
    // Drive the idle word by default and override per instruction phase.
    always_comb begin
        bus_regA_sel = 1'b1;
        nLa          = 1'b1;
        nLb          = 1'b1;
        Ea           = 1'b0;
        Eu           = 1'b0;
        sub          = 1'b0;
        out_strobe   = 1'b0;

        if ((state_q == StExec1) && !skip_q) begin
            case (ir_q)
                OpAdd: begin
                    Eu  = 1'b1;
                    nLa = 1'b0;
                end
                OpSub: begin
                    Eu  = 1'b1;
                    nLa = 1'b0;
                    sub = 1'b1;
                end
                OpOut: begin
                    bus_regA_sel = 1'b0;
                    out_strobe   = 1'b1;
                end
                default: begin
                end
            endcase
        end else if (state_q == StExec2) begin
            // Load phase of LDA/LDB; the input buffer settled during EXEC1.
            case (ir_q)
                OpLda:   nLa = 1'b0;
                OpLdb:   nLb = 1'b0;
                default: begin
                end
            endcase
        end
    end

    assign halted = (state_q == StHalted);

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    // The accumulator bus driver is reserved and must never fight the ALU.
    a_ea_never: assert property (@(posedge clk) disable iff (rst) !Ea);
    a_no_contention: assert property (@(posedge clk) disable iff (rst) !(Ea && Eu));
    a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count_q == '0)));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));
    a_halt_no_pop: assert property (@(posedge clk) disable iff (rst)
        !((state_q == StHalted) && pop));

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed scenarios with cycle-exact expectations
// plus a randomized run checked against an instruction-expansion model.
module tb_adder_sequencer;

    localparam int DEPTH = 4;

    localparam logic [2:0] NOP = 3'd0, LDA = 3'd1, LDB = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, OUT = 3'd5, SKZ = 3'd6, HALT = 3'd7;

    // Control word packing: {bus_regA_sel, nLa, nLb, Ea, Eu, sub, out_strobe}
    localparam logic [6:0] W_IDLE = 7'b1110000;
    localparam logic [6:0] W_LDA  = 7'b1010000;
    localparam logic [6:0] W_LDB  = 7'b1100000;
    localparam logic [6:0] W_ADD  = 7'b1010100;
    localparam logic [6:0] W_SUB  = 7'b1010110;
    localparam logic [6:0] W_OUT  = 7'b0110001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [2:0] instr_op = 3'd0;
    logic       instr_ready;
    logic       resume = 1'b0;
    logic       cf_in = 1'b0;
    logic       zf_in = 1'b0;
    logic       bus_regA_sel, nLa, nLb, Ea, Eu, sub, out_strobe;
    logic       halted, cf_q, zf_q;
    logic [7:0] retired;
    logic [6:0] ctrl;

    int errors = 0;
    int checks = 0;

    adder_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_op    (instr_op),
        .instr_ready (instr_ready),
        .resume      (resume),
        .cf_in       (cf_in),
        .zf_in       (zf_in),
        .bus_regA_sel(bus_regA_sel),
        .nLa         (nLa),
        .nLb         (nLb),
        .Ea          (Ea),
        .Eu          (Eu),
        .sub         (sub),
        .out_strobe  (out_strobe),
        .halted      (halted),
        .cf_q        (cf_q),
        .zf_q        (zf_q),
        .retired     (retired)
    );

    assign ctrl = {bus_regA_sel, nLa, nLb, Ea, Eu, sub, out_strobe};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: a FIFO of opcodes plus the list of control words the
    // instruction in flight still has to present, one per cycle.
    // ------------------------------------------------------------------
    logic [2:0] m_q[$];
    logic [6:0] m_cur[$];
    logic [2:0] m_op;
    bit         m_disc, m_skip, m_cf, m_zf, m_halted;
    int         m_ret;

    task automatic model_reset();
        m_q.delete();
        m_cur.delete();
        m_op = NOP; m_disc = 0; m_skip = 0; m_cf = 0; m_zf = 0; m_halted = 0; m_ret = 0;
    endtask

    task automatic model_expand(input logic [2:0] op);
        m_cur.delete();
        case (op)
            LDA:     begin m_cur.push_back(W_IDLE); m_cur.push_back(W_LDA); end
            LDB:     begin m_cur.push_back(W_IDLE); m_cur.push_back(W_LDB); end
            ADD:     begin m_cur.push_back(W_ADD); m_cur.push_back(W_IDLE); end
            SUB:     begin m_cur.push_back(W_SUB); m_cur.push_back(W_IDLE); end
            OUT:     m_cur.push_back(W_OUT);
            default: m_cur.push_back(W_IDLE);
        endcase
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit v, input logic [2:0] op, input bit res,
                              input bit cf, input bit zf);
        int         qs;
        bit         fin;
        logic [2:0] head;
        qs  = m_q.size();
        fin = 0;
        if (m_halted) begin
            if (res) m_halted = 0;
        end else if (m_cur.size() == 0) begin
            fin = 1;
        end else begin
            void'(m_cur.pop_front());
            if (m_cur.size() == 0) begin
                fin = 1;
                if (!m_disc) begin
                    m_ret = (m_ret + 1) % 256;
                    if (m_op == ADD || m_op == SUB) begin m_cf = cf; m_zf = zf; end
                    if (m_op == SKZ && m_zf) m_skip = 1;
                    if (m_op == HALT) begin m_halted = 1; fin = 0; end
                end
            end
        end
        if (fin && qs > 0) begin
            head   = m_q.pop_front();
            m_op   = head;
            m_disc = m_skip;
            if (m_skip) begin
                m_skip = 0;
                m_cur.delete();
                m_cur.push_back(W_IDLE);
            end else begin
                model_expand(head);
            end
        end
        if (v && qs < DEPTH) m_q.push_back(op);
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change and outputs are sampled at negedge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; instr_valid = 1'b0; instr_op = NOP; resume = 1'b0;
        cf_in = 1'b0; zf_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic push_op(input logic [2:0] op);
        int n;
        n = 0;
        while (!instr_ready && n < 100) begin tick(); n++; end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL push_wait: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
        end
        instr_valid = 1'b1; instr_op = op;
        tick();
        instr_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (ctrl !== W_IDLE || instr_ready !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ctrl=%b ready=%b halted=%b, required %b 1 0",
                     ctrl, instr_ready, halted, W_IDLE);
        end
        push_op(LDA);
        push_op(ADD);
        tick();
        // LDA is in its load cycle now
        checks++;
        if (ctrl !== W_LDA) begin
            errors++; $display("FAIL reset_pre_load: ctrl=%b required %b", ctrl, W_LDA);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== W_IDLE) begin
            errors++; $display("FAIL reset_async_ctrl: ctrl=%b required %b", ctrl, W_IDLE);
        end
        checks++;
        if (instr_ready !== 1'b1 || retired !== 8'd0) begin
            errors++;
            $display("FAIL reset_async_queue: ready=%b retired=%0d required 1 0", instr_ready, retired);
        end
        checks++;
        if ({halted, cf_q, zf_q} !== 3'b000) begin
            errors++; $display("FAIL reset_async_flags: halted/cf/zf=%b required 000", {halted, cf_q, zf_q});
        end
        // A push offered while reset is held must be ignored
        instr_valid = 1'b1; instr_op = OUT;
        @(negedge clk);
        instr_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ctrl !== W_IDLE || retired !== 8'd0 || instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_release c%0d: ctrl=%b retired=%0d ready=%b required %b 0 1",
                         c, ctrl, retired, instr_ready, W_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_lda_ldb_add();
        logic [6:0] exp_w [9];
        exp_w = '{W_IDLE, W_IDLE, W_IDLE, W_LDA, W_IDLE, W_LDB, W_ADD, W_IDLE, W_IDLE};
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c >= 1) begin
                checks++;
                if (ctrl !== exp_w[c]) begin
                    errors++;
                    $display("FAIL lda_ldb_add cycle %0d: ctrl=%b required %b", c, ctrl, exp_w[c]);
                end
            end
            if (c == 7) begin
                checks++;
                if (retired !== 8'd2) begin
                    errors++; $display("FAIL lda_ldb_add retired@7: got %0d required 2", retired);
                end
            end
            if (c == 8) begin
                checks++;
                if (retired !== 8'd3) begin
                    errors++; $display("FAIL lda_ldb_add retired@8: got %0d required 3", retired);
                end
            end
            instr_valid = (c <= 2);
            instr_op    = (c == 0) ? LDA : ((c == 1) ? LDB : ADD);
            tick();
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_sub_flags();
        apply_reset();
        instr_valid = 1'b1; instr_op = SUB;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++;
        if (ctrl !== W_SUB) begin
            errors++; $display("FAIL sub_exec1: ctrl=%b required %b", ctrl, W_SUB);
        end
        tick();
        checks++;
        if (ctrl !== W_IDLE || {cf_q, zf_q} !== 2'b00) begin
            errors++; $display("FAIL sub_exec2: ctrl=%b cf/zf=%b required %b 00", ctrl, {cf_q, zf_q}, W_IDLE);
        end
        cf_in = 1'b1; zf_in = 1'b1;
        tick();
        cf_in = 1'b0; zf_in = 1'b0;
        checks++;
        if ({cf_q, zf_q} !== 2'b11 || retired !== 8'd1) begin
            errors++;
            $display("FAIL sub_flags: cf/zf=%b retired=%0d required 11 1", {cf_q, zf_q}, retired);
        end
        // A following ADD reloads both flags from whatever the ALU reports
        cf_in = 1'b0; zf_in = 1'b1;
        push_op(ADD);
        repeat (4) tick();
        checks++;
        if ({cf_q, zf_q} !== 2'b01 || retired !== 8'd2) begin
            errors++;
            $display("FAIL add_flags: cf/zf=%b retired=%0d required 01 2", {cf_q, zf_q}, retired);
        end
        zf_in = 1'b0;
    endtask

    task automatic test_halt_backpressure();
        int accepted;
        int n;
        apply_reset();
        instr_valid = 1'b1; instr_op = HALT;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || retired !== 8'd1) begin
            errors++; $display("FAIL halt_enter: halted=%b retired=%0d required 1 1", halted, retired);
        end
        accepted = 0;
        instr_valid = 1'b1; instr_op = NOP;
        for (int i = 0; i < 6; i++) begin
            if (instr_ready) accepted++;
            tick();
        end
        checks++;
        if (accepted != 4 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL halt_fill: accepted=%0d ready=%b required 4 0", accepted, instr_ready);
        end
        checks++;
        if (halted !== 1'b1 || ctrl !== W_IDLE) begin
            errors++; $display("FAIL halt_hold: halted=%b ctrl=%b required 1 %b", halted, ctrl, W_IDLE);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if (halted !== 1'b0 || instr_ready !== 1'b0) begin
            errors++; $display("FAIL halt_resume: halted=%b ready=%b required 0 0", halted, instr_ready);
        end
        tick();
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL halt_slot_free: ready=%b required 1", instr_ready);
        end
        tick();
        instr_valid = 1'b0;
        n = 0;
        while (retired !== 8'd6 && n < 40) begin tick(); n++; end
        repeat (5) tick();
        checks++;
        if (retired !== 8'd6 || instr_ready !== 1'b1 || ctrl !== W_IDLE) begin
            errors++;
            $display("FAIL halt_drain: retired=%0d ready=%b ctrl=%b required 6 1 %b",
                     retired, instr_ready, ctrl, W_IDLE);
        end
    endtask

    task automatic test_skz();
        bit seen;
        apply_reset();
        cf_in = 1'b0; zf_in = 1'b1;
        push_op(ADD);
        repeat (5) tick();
        checks++;
        if (zf_q !== 1'b1 || retired !== 8'd1) begin
            errors++; $display("FAIL skz_setup: zf_q=%b retired=%0d required 1 1", zf_q, retired);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_strobe === 1'b1) seen = 1;
            instr_valid = (c < 3);
            instr_op    = (c == 0) ? SKZ : ((c == 1) ? OUT : NOP);
            tick();
        end
        instr_valid = 1'b0;
        checks++;
        if (seen || retired !== 8'd3) begin
            errors++; $display("FAIL skz_discard: strobe_seen=%b retired=%0d required 0 3", seen, retired);
        end
        // Skip flag is consumed: a new OUT must display
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_strobe === 1'b1) seen = 1;
            instr_valid = (c == 0); instr_op = OUT;
            tick();
        end
        instr_valid = 1'b0;
        checks++;
        if (!seen || retired !== 8'd4) begin
            errors++; $display("FAIL skz_cleared: strobe_seen=%b retired=%0d required 1 4", seen, retired);
        end
        // SKZ on an empty queue waits for the next push
        push_op(SKZ);
        repeat (6) tick();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_strobe === 1'b1) seen = 1;
            instr_valid = (c == 0); instr_op = OUT;
            tick();
        end
        instr_valid = 1'b0;
        checks++;
        if (seen || retired !== 8'd5) begin
            errors++; $display("FAIL skz_wait: strobe_seen=%b retired=%0d required 0 5", seen, retired);
        end
        zf_in = 1'b0;
    endtask

    task automatic test_reset_mid_add();
        int n;
        apply_reset();
        push_op(LDA);
        push_op(ADD);
        push_op(NOP);
        n = 0;
        while (Eu !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (ctrl !== W_ADD || retired !== 8'd1) begin
            errors++; $display("FAIL mid_add_reach: ctrl=%b retired=%0d required %b 1", ctrl, retired, W_ADD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (Eu !== 1'b0 || nLa !== 1'b1) begin
            errors++; $display("FAIL mid_add_reset: Eu=%b nLa=%b required 0 1", Eu, nLa);
        end
        checks++;
        if (instr_ready !== 1'b1 || retired !== 8'd0) begin
            errors++; $display("FAIL mid_add_clear: ready=%b retired=%0d required 1 0", instr_ready, retired);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (ctrl !== W_IDLE || retired !== 8'd0) begin
            errors++; $display("FAIL mid_add_after: ctrl=%b retired=%0d required %b 0", ctrl, retired, W_IDLE);
        end
    endtask

    task automatic test_nop_wrap();
        int sent;
        int bad;
        bit saw255;
        apply_reset();
        sent = 0; bad = 0; saw255 = 0;
        instr_op = NOP;
        for (int c = 0; c < 300; c++) begin
            instr_valid = (sent < 256);
            if (nLa !== 1'b1 || nLb !== 1'b1) bad++;
            if (retired === 8'd255) saw255 = 1;
            if (instr_valid && instr_ready) sent++;
            tick();
        end
        instr_valid = 1'b0;
        checks++;
        if (sent != 256 || bad != 0) begin
            errors++; $display("FAIL nop_stream: sent=%0d load_glitches=%0d required 256 0", sent, bad);
        end
        checks++;
        if (!saw255 || retired !== 8'd0) begin
            errors++; $display("FAIL nop_wrap: saw255=%b retired=%0d required 1 0", saw255, retired);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_w;
        logic [2:0] op;
        bit         v, res, cf, zf;
        apply_reset();
        for (int c = 0; c < 1200; c++) begin
            exp_w = (m_cur.size() != 0) ? m_cur[0] : W_IDLE;
            checks++;
            if (ctrl !== exp_w) begin
                errors++; $display("FAIL rand_ctrl c%0d: ctrl=%b required %b", c, ctrl, exp_w);
            end
            checks++;
            if (instr_ready !== (m_q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready c%0d: ready=%b required %b", c, instr_ready, m_q.size() < DEPTH);
            end
            checks++;
            if ({halted, cf_q, zf_q} !== {m_halted, m_cf, m_zf}) begin
                errors++;
                $display("FAIL rand_status c%0d: halted/cf/zf=%b required %b", c,
                         {halted, cf_q, zf_q}, {m_halted, m_cf, m_zf});
            end
            checks++;
            if (retired !== 8'(m_ret)) begin
                errors++; $display("FAIL rand_retired c%0d: got %0d required %0d", c, retired, m_ret);
            end
            v   = ($urandom_range(0, 9) < 6);
            op  = 3'($urandom_range(0, 7));
            if (op == HALT && $urandom_range(0, 3) != 0) op = NOP;
            res = ($urandom_range(0, 5) == 0);
            cf  = 1'($urandom_range(0, 1));
            zf  = 1'($urandom_range(0, 1));
            instr_valid = v; instr_op = op; resume = res; cf_in = cf; zf_in = zf;
            model_edge(v, op, res, cf, zf);
            tick();
        end
        instr_valid = 1'b0; resume = 1'b0; cf_in = 1'b0; zf_in = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lda_ldb_add();
        test_sub_flags();
        test_halt_backpressure();
        test_skz();
        test_reset_mid_add();
        test_nop_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue depth in entries (power of two, >= 2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_op  input  3  opcode: 000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUT, 110 SKZ, 111 HALT.
REQ-006 instr_ready  output  1  queue can accept an instruction.
REQ-007 resume  input  1  one-cycle pulse that leaves HALTED.
REQ-008 cf_in, zf_in  input  1 each  carry/zero flags from the ALU.
REQ-009 bus_regA_sel  output  1  1 = uo_out shows bus, 0 = shows accumulator.
REQ-010 nLa, nLb  output  1 each  A/B register load, active-low.
REQ-011 Ea, Eu  output  1 each  accumulator / ALU bus drive, active-high.
REQ-012 sub  output  1  0 add, 1 subtract.
REQ-013 out_strobe  output  1  high for the single OUT display cycle.
REQ-014 halted  output  1  sequencer in HALTED state.
REQ-015 cf_q, zf_q  output  1 each  latched flags.
REQ-016 retired  output  8  count of completed instructions.

Function
REQ-017 Idle control word SHALL be: nLa=1, nLb=1, Ea=0, Eu=0, sub=0, bus_regA_sel=1, out_strobe=0; driven in every state/cycle not listed below.
REQ-018 instr_ready SHALL equal (count < DEPTH), computed from registered count only; a pop in the same cycle does not raise it.
REQ-019 Push occurs when instr_valid && instr_ready; FIFO order preserved; simultaneous push and pop leaves count unchanged.
REQ-020 States: IDLE, EXEC1, EXEC2, HALTED; all transitions on clk.
REQ-021 IDLE: if queue non-empty, pop head into instruction register and go EXEC1; else stay.
REQ-022 LDA/LDB: EXEC1 idle word (input buffer settles); EXEC2 nLa=0 (LDA) or nLb=0 (LDB), Ea=Eu=0; then IDLE.
REQ-023 ADD/SUB: EXEC1 Eu=1, nLa=0, sub=1 for SUB only; EXEC2 idle word, cf_q/zf_q load cf_in/zf_in at end of EXEC2; then IDLE.
REQ-024 OUT: EXEC1 bus_regA_sel=0, out_strobe=1; then IDLE.
REQ-025 NOP: EXEC1 idle word; then IDLE.
REQ-026 SKZ: EXEC1 idle word; if zf_q=1 set skip flag; then IDLE.
REQ-027 With skip flag set, the next popped instruction SHALL be discarded in EXEC1 (idle word, not retired), skip flag cleared; if queue empty, skip waits for the next push.
REQ-028 HALT: EXEC1 -> HALTED; HALTED holds idle word, halted=1, no pops, pushes still accepted; resume=1 -> IDLE next cycle.
REQ-029 resume outside HALTED SHALL be ignored.
REQ-030 retired SHALL increment by 1 on the final cycle of every non-discarded instruction (HALT on entering HALTED), wrapping 255 -> 0.
REQ-031 Ea SHALL never be 1 (accumulator bus drive reserved); Ea and Eu never both 1.
REQ-032 Latency push-to-first-control-cycle on empty idle queue: 2 cycles.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, queue empty (instr_ready=1), skip flag 0, cf_q=zf_q=0, retired=0, halted=0, idle control word, regardless of operation in progress.
REQ-034 Release of rst SHALL take effect on the next rising clk; no instruction popped in the release cycle.

Verification
REQ-035 Push LDA, LDB, ADD on empty queue -> nLa=0 at cycle 3, nLb=0 at cycle 5, Eu=1 with nLa=0 at cycle 6, retired=3 after cycle 7.
REQ-036 SUB with cf_in=1, zf_in=1 during EXEC2 -> sub=1 in EXEC1, cf_q=zf_q=1 afterward.
REQ-037 Push 5 instructions back-to-back while halted -> instr_ready=0 after 4 accepted, 5th held until resume frees an entry.
REQ-038 zf_q=1, queue SKZ, OUT, NOP -> OUT discarded (no out_strobe), retired=2.
REQ-039 Assert rst during ADD EXEC1 -> Eu=0, nLa=1 same cycle, queue empty, retired=0.
REQ-040 256 NOPs -> retired wraps to 0; nLa/nLb stay 1 throughout.
